// File: rtl/instr_encoder.sv
// instr_encoder: encodes field-level requests into ARM-subset words and streams them into instruction memory.
// Optional macro ENC_ILLEGAL_CHK_EN: also reject unsupported DP cmds and nonzero ReqSrc[23:12] for DP/MEM.
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                       CLK,
    input  logic                       RESETn,
    input  logic                       ReqValid,
    output logic                       ReqReady,
    input  logic [1:0]                 ReqClass,
    input  logic [3:0]                 ReqCond,
    input  logic [3:0]                 ReqCmd,
    input  logic                       ReqI,
    input  logic                       ReqS,
    input  logic                       ReqU,
    input  logic                       ReqL,
    input  logic [3:0]                 ReqRn,
    input  logic [3:0]                 ReqRd,
    input  logic [23:0]                ReqSrc,
    input  logic                       Rewind,
    input  logic                       IMemReady,
    output logic                       IMemWE,
    output logic [ADDR_W-1:0]          IMemAddr,
    output logic [31:0]                IMemWD,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       ErrIllegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic               enc_valid_reg;
    logic [31:0]        enc_word_reg;
    logic               err_reg;
    logic [31:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [ADDR_W-1:0]  addr_reg;

    logic [31:0]        enc_word_next;
    logic               req_illegal;
    logic               accept, full, push, pop, dp_cmp;

    assign full     = (count_reg == FULL_CNT);
    assign ReqReady = ~full;
    assign accept   = ReqValid & ReqReady;
    assign dp_cmp   = (ReqCmd[3:1] == 3'b101);
    assign pop      = (state_reg == WRITE) && IMemReady && (count_reg != '0);
    // The encode stage is an extra slot: it drains into the FIFO unless the FIFO is full and not popping.
    assign push     = enc_valid_reg && (!full || pop);

`ifdef ENC_ILLEGAL_CHK_EN
    logic dp_cmd_ok;
    logic src_hi_nz;
    assign dp_cmd_ok = (ReqCmd == 4'b0100) || (ReqCmd == 4'b0010) || (ReqCmd == 4'b0000) ||
                       (ReqCmd == 4'b1100) || (ReqCmd == 4'b1010) || (ReqCmd == 4'b1011);
    assign src_hi_nz = |ReqSrc[23:12];
`endif

    always_comb begin
        enc_word_next = '0;
        req_illegal   = 1'b0;
        case (ReqClass)
            2'b00: begin
                // CMP/CMN only make sense as flag-setting compares with no destination.
                enc_word_next = {ReqCond, 2'b00, ReqI, ReqCmd, ReqS | dp_cmp, ReqRn,
                                 dp_cmp ? 4'b0000 : ReqRd, ReqSrc[11:0]};
`ifdef ENC_ILLEGAL_CHK_EN
                req_illegal = !dp_cmd_ok || src_hi_nz;
`endif
            end
            2'b01: begin
                enc_word_next = {ReqCond, 2'b01, 1'b0, 1'b1, ReqU, 1'b0, 1'b0, ReqL,
                                 ReqRn, ReqRd, ReqSrc[11:0]};
`ifdef ENC_ILLEGAL_CHK_EN
                req_illegal = src_hi_nz;
`endif
            end
            2'b10: begin
                enc_word_next = {ReqCond, 3'b101, 1'b0, ReqSrc};
            end
            default: begin
                req_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            enc_valid_reg <= 1'b0;
            enc_word_reg  <= '0;
            err_reg       <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            addr_reg      <= BASE_ADDR;
        end else begin
            err_reg <= accept & req_illegal;
            if (accept) begin
                enc_valid_reg <= ~req_illegal;
                enc_word_reg  <= enc_word_next;
            end else if (push) begin
                enc_valid_reg <= 1'b0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            if (Rewind) begin
                addr_reg <= BASE_ADDR;
            end else if (pop) begin
                addr_reg <= addr_reg + ADDR_W'(4);
            end
        end
    end

    // Storage is left unreset so it maps onto plain RAM; occupancy is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= enc_word_reg;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (count_reg != '0 || push) state_next = WRITE;
            WRITE:   if (count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        IMemWE = 1'b0;
        IMemWD = '0;
        if (state_reg == WRITE) begin
            IMemWE = 1'b1;
            IMemWD = mem[rd_ptr_reg];
        end
    end

    assign IMemAddr   = addr_reg;
    assign Count      = count_reg;
    assign ErrIllegal = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized traffic against a field-level model.
module tb_instr_encoder;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        ReqValid;
    logic        ReqReady;
    logic [1:0]  ReqClass;
    logic [3:0]  ReqCond;
    logic [3:0]  ReqCmd;
    logic        ReqI, ReqS, ReqU, ReqL;
    logic [3:0]  ReqRn, ReqRd;
    logic [23:0] ReqSrc;
    logic        Rewind;
    logic        IMemReady;
    logic        IMemWE;
    logic [9:0]  IMemAddr;
    logic [31:0] IMemWD;
    logic [2:0]  Count;
    logic        ErrIllegal;

    always #5 CLK = ~CLK;

    instr_encoder dut (
        .CLK(CLK), .RESETn(RESETn), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqClass(ReqClass), .ReqCond(ReqCond), .ReqCmd(ReqCmd), .ReqI(ReqI), .ReqS(ReqS),
        .ReqU(ReqU), .ReqL(ReqL), .ReqRn(ReqRn), .ReqRd(ReqRd), .ReqSrc(ReqSrc),
        .Rewind(Rewind), .IMemReady(IMemReady), .IMemWE(IMemWE), .IMemAddr(IMemAddr),
        .IMemWD(IMemWD), .Count(Count), .ErrIllegal(ErrIllegal)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          accepts = 0;
    int          last_acc_cyc = 0;
    int          err_pulses = 0;
    int          last_err_cyc = 0;
    int          exp_err = 0;
    bit          rand_ready = 0;
    logic [9:0]  m_addr = '0;
    logic [31:0] exp_w[$];
    wr_t         obs_q[$];

    // Reference encoding straight from the field layout; returns {illegal, word}.
    function automatic logic [32:0] model(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
                                          input logic i, input logic s, input logic u, input logic l,
                                          input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] src);
        logic [31:0] w;
        logic        ill;
        logic        cmpx;
        w = 32'd0;
        ill = 1'b0;
        cmpx = (cmd == 4'd10) || (cmd == 4'd11);
        case (cls)
            2'd0: begin
                w = (32'(cond) << 28) | (32'(i) << 25) | (32'(cmd) << 21) | (32'(s | cmpx) << 20) |
                    (32'(rn) << 16) | (cmpx ? 32'd0 : (32'(rd) << 12)) | 32'(src[11:0]);
`ifdef ENC_ILLEGAL_CHK_EN
                ill = !(cmd == 4'd0 || cmd == 4'd2 || cmd == 4'd4 || cmd == 4'd12 || cmpx) || (src >= 24'h1000);
`endif
            end
            2'd1: begin
                w = (32'(cond) << 28) | 32'h0500_0000 | (32'(u) << 23) | (32'(l) << 20) |
                    (32'(rn) << 16) | (32'(rd) << 12) | 32'(src[11:0]);
`ifdef ENC_ILLEGAL_CHK_EN
                ill = (src >= 24'h1000);
`endif
            end
            2'd2: w = (32'(cond) << 28) | 32'h0A00_0000 | 32'(src);
            default: ill = 1'b1;
        endcase
        return {ill, w};
    endfunction

    // One clock: sample outputs mid-cycle, then advance past the rising edge.
    task automatic tick();
        wr_t w;
        @(negedge CLK);
        if (IMemWE && IMemReady) begin
            w.addr = {22'd0, IMemAddr};
            w.data = IMemWD;
            w.cyc  = cyc;
            obs_q.push_back(w);
        end
        if (ReqValid && ReqReady) begin
            accepts++;
            last_acc_cyc = cyc;
        end
        if (ErrIllegal) begin
            err_pulses++;
            last_err_cyc = cyc;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (rand_ready) IMemReady = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
                         input logic i, input logic s, input logic u, input logic l,
                         input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] src);
        ReqClass = cls; ReqCond = cond; ReqCmd = cmd; ReqI = i; ReqS = s;
        ReqU = u; ReqL = l; ReqRn = rn; ReqRd = rd; ReqSrc = src;
    endtask

    task automatic send(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
                        input logic i, input logic s, input logic u, input logic l,
                        input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] src);
        logic [32:0] m;
        int          a0;
        bit          got;
        m = model(cls, cond, cmd, i, s, u, l, rn, rd, src);
        drive(cls, cond, cmd, i, s, u, l, rn, rd, src);
        ReqValid = 1'b1;
        a0 = accepts;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            tick();
            if (accepts != a0) got = 1;
        end
        ReqValid = 1'b0;
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: accepted=0 required=1");
        end else if (m[32]) begin
            exp_err++;
        end else begin
            exp_w.push_back(m[31:0]);
        end
    endtask

    task automatic drain();
        int idle;
        bit ok;
        idle = 0;
        ok = 0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            tick();
            if (!IMemWE && Count == 3'd0) idle++;
            else idle = 0;
            if (idle >= 3) ok = 1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: Count=%0d IMemWE=%0b required idle", Count, IMemWE);
        end
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESETn = 1'b1;
        n_checks++; if (ReqReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ReqReady); end
        n_checks++; if (IMemWE !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", IMemWE); end
        n_checks++; if (IMemAddr !== 10'h000) begin n_fail++; $display("FAIL reset_addr: got %h want 000", IMemAddr); end
        n_checks++; if (IMemWD !== 32'h0) begin n_fail++; $display("FAIL reset_wd: got %h want 0", IMemWD); end
        n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", Count); end
        n_checks++; if (ErrIllegal !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", ErrIllegal); end
        $display("reset: checked reset values");
    endtask

    task automatic test_directed();
        int acc0;
        logic [31:0] want_d[4];
        logic [9:0]  want_a[4];
        obs_q.delete(); exp_w.delete();
        IMemReady = 1'b1;
        send(2'd0, 4'hE, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 24'h005);
        acc0 = last_acc_cyc;
        send(2'd0, 4'hE, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd7, 24'h004);
        drain();
        Rewind = 1'b1;
        tick();
        Rewind = 1'b0;
        send(2'd1, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 24'h008);
        send(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 24'hFFFFFE);
        drain();
        want_d[0] = 32'hE2812005; want_a[0] = 10'h000;
        want_d[1] = 32'hE1530004; want_a[1] = 10'h004;
        want_d[2] = 32'hE5101008; want_a[2] = 10'h000;
        want_d[3] = 32'hEAFFFFFE; want_a[3] = 10'h004;
        n_checks++;
        if (obs_q.size() != 4) begin n_fail++; $display("FAIL directed_count: got %0d want 4", obs_q.size()); end
        for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k].data !== want_d[k] || obs_q[k].addr !== {22'd0, want_a[k]}) begin
                n_fail++;
                $display("FAIL directed_word%0d: got %h@%h want %h@%h", k, obs_q[k].data, obs_q[k].addr, want_d[k], want_a[k]);
            end
            $display("directed: write %0d data=%h addr=%h", k, obs_q[k].data, obs_q[k].addr);
        end
        if (obs_q.size() > 0) begin
            n_checks++;
            if (obs_q[0].cyc - acc0 != 2) begin
                n_fail++;
                $display("FAIL directed_latency: got %0d want 2", obs_q[0].cyc - acc0);
            end
        end
        m_addr = 10'h008;
    endtask

    task automatic test_backpressure();
        int          idx;
        int          a0;
        logic [3:0]  rn_v;
        logic [11:0] src_v;
        logic [32:0] m;
        logic [9:0]  hold_a;
        logic [31:0] hold_d;
        obs_q.delete(); exp_w.delete();
        IMemReady = 1'b0;
        idx = 0;
        rn_v = 4'($urandom); src_v = 12'($urandom);
        drive(2'd0, 4'hE, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, rn_v, 4'd5, {12'd0, src_v});
        ReqValid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            a0 = accepts;
            tick();
            if (accepts != a0) begin
                m = model(2'd0, 4'hE, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, rn_v, 4'd5, {12'd0, src_v});
                exp_w.push_back(m[31:0]);
                idx++;
                rn_v = 4'($urandom); src_v = 12'($urandom);
                drive(2'd0, 4'hE, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, rn_v, 4'd5, {12'd0, src_v});
            end
        end
        ReqValid = 1'b0;
        n_checks++; if (idx != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d want 5", idx); end
        n_checks++; if (Count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", Count); end
        n_checks++; if (ReqReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", ReqReady); end
        n_checks++; if (IMemWE !== 1'b1) begin n_fail++; $display("FAIL bp_we: got %b want 1", IMemWE); end
        hold_a = IMemAddr; hold_d = IMemWD;
        repeat (3) tick();
        n_checks++;
        if (IMemAddr !== hold_a || IMemWD !== hold_d) begin
            n_fail++;
            $display("FAIL bp_hold: got %h@%h want %h@%h", IMemWD, IMemAddr, hold_d, hold_a);
        end
        IMemReady = 1'b1;
        drain();
        n_checks++;
        if (obs_q.size() != exp_w.size()) begin n_fail++; $display("FAIL bp_writes: got %0d want %0d", obs_q.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size(); k++) begin
            if (k < obs_q.size()) begin
                n_checks++;
                if (obs_q[k].data !== exp_w[k] || obs_q[k].addr !== {22'd0, m_addr}) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: got %h@%h want %h@%h", k, obs_q[k].data, obs_q[k].addr, exp_w[k], m_addr);
                end
                $display("backpressure: write %0d data=%h addr=%h", k, obs_q[k].data, obs_q[k].addr);
            end
            m_addr = m_addr + 10'd4;
        end
    endtask

    task automatic test_illegal();
        int e0;
        int c0;
        obs_q.delete(); exp_w.delete();
        IMemReady = 1'b1;
        e0 = err_pulses;
        drive(2'd3, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 24'h005);
        ReqValid = 1'b1;
        c0 = cyc;
        tick();
        ReqValid = 1'b0;
        repeat (4) tick();
        n_checks++; if (err_pulses - e0 != 1) begin n_fail++; $display("FAIL illegal_pulses: got %0d want 1", err_pulses - e0); end
        n_checks++; if (last_err_cyc != c0 + 1) begin n_fail++; $display("FAIL illegal_timing: got %0d want %0d", last_err_cyc, c0 + 1); end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL illegal_write: got %0d writes want 0", obs_q.size()); end
        $display("illegal: class 11 pulses=%0d writes=%0d", err_pulses - e0, obs_q.size());
        e0 = err_pulses;
        send(2'd0, 4'hE, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 24'h003);
        drain();
`ifdef ENC_ILLEGAL_CHK_EN
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL eor_write: got %0d writes want 0", obs_q.size()); end
        n_checks++; if (err_pulses - e0 != 1) begin n_fail++; $display("FAIL eor_err: got %0d want 1", err_pulses - e0); end
`else
        n_checks++; if (err_pulses - e0 != 0) begin n_fail++; $display("FAIL eor_err: got %0d want 0", err_pulses - e0); end
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0].data !== 32'hE0212003 || obs_q[0].addr !== {22'd0, m_addr}) begin
            n_fail++;
            $display("FAIL eor_write: got %0d writes first %h want E0212003@%h", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].data : 32'h0, m_addr);
        end
        m_addr = m_addr + 10'd4;
`endif
        $display("illegal: EOR pulses=%0d writes=%0d", err_pulses - e0, obs_q.size());
    endtask

    task automatic test_random();
        int          e0;
        logic [1:0]  cls;
        logic [23:0] src;
        obs_q.delete(); exp_w.delete();
        exp_err = 0;
        e0 = err_pulses;
        rand_ready = 1;
        for (int n = 0; n < 400; n++) begin
            cls = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            src = ($urandom_range(0, 1) != 0) ? 24'($urandom & 32'hFFF) : 24'($urandom);
            send(cls, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 4'($urandom), 4'($urandom), src);
        end
        rand_ready = 0;
        IMemReady = 1'b1;
        drain();
        n_checks++;
        if (obs_q.size() != exp_w.size()) begin n_fail++; $display("FAIL rand_writes: got %0d want %0d", obs_q.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size(); k++) begin
            if (k < obs_q.size()) begin
                n_checks++;
                if (obs_q[k].data !== exp_w[k] || obs_q[k].addr !== {22'd0, m_addr}) begin
                    n_fail++;
                    $display("FAIL rand_word%0d: got %h@%h want %h@%h", k, obs_q[k].data, obs_q[k].addr, exp_w[k], m_addr);
                end
                $display("random: write %0d data=%h addr=%h", k, obs_q[k].data, obs_q[k].addr);
            end
            m_addr = m_addr + 10'd4;
        end
        n_checks++;
        if (err_pulses - e0 != exp_err) begin n_fail++; $display("FAIL rand_errors: got %0d want %0d", err_pulses - e0, exp_err); end
    endtask

    task automatic test_wrap_rewind();
        int          n;
        logic [9:0]  gap;
        logic [9:0]  first_a;
        bit          seen;
        obs_q.delete(); exp_w.delete();
        IMemReady = 1'b1;
        gap = 10'h3FC - m_addr;
        n = int'(gap >> 2);
        for (int k = 0; k < n + 2; k++) begin
            send(2'd0, 4'hE, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 24'($urandom & 32'hFFF));
        end
        drain();
        n_checks++;
        if (obs_q.size() != n + 2) begin n_fail++; $display("FAIL wrap_writes: got %0d want %0d", obs_q.size(), n + 2); end
        for (int k = 0; k < exp_w.size(); k++) begin
            if (k < obs_q.size()) begin
                n_checks++;
                if (obs_q[k].data !== exp_w[k] || obs_q[k].addr !== {22'd0, m_addr}) begin
                    n_fail++;
                    $display("FAIL wrap_word%0d: got %h@%h want %h@%h", k, obs_q[k].data, obs_q[k].addr, exp_w[k], m_addr);
                end
            end
            m_addr = m_addr + 10'd4;
        end
        if (obs_q.size() == n + 2) begin
            n_checks++;
            if (obs_q[n].addr !== 32'h3FC || obs_q[n + 1].addr !== 32'h000) begin
                n_fail++;
                $display("FAIL wrap_edge: got %h,%h want 3fc,000", obs_q[n].addr, obs_q[n + 1].addr);
            end
            $display("wrap: writes at %h then %h", obs_q[n].addr, obs_q[n + 1].addr);
        end
        obs_q.delete(); exp_w.delete();
        IMemReady = 1'b0;
        send(2'd0, 4'hE, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd6, 24'h00A);
        send(2'd2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 24'h123456);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (IMemWE) seen = 1;
            else tick();
        end
        first_a = m_addr;
        Rewind = 1'b1;
        IMemReady = 1'b1;
        tick();
        Rewind = 1'b0;
        drain();
        n_checks++;
        if (obs_q.size() != 2 || exp_w.size() != 2) begin
            n_fail++;
            $display("FAIL rewind_writes: got %0d want 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0].addr !== {22'd0, first_a} || obs_q[0].data !== exp_w[0]) begin
                n_fail++;
                $display("FAIL rewind_first: got %h@%h want %h@%h", obs_q[0].data, obs_q[0].addr, exp_w[0], first_a);
            end
            n_checks++;
            if (obs_q[1].addr !== 32'h000 || obs_q[1].data !== exp_w[1]) begin
                n_fail++;
                $display("FAIL rewind_second: got %h@%h want %h@000", obs_q[1].data, obs_q[1].addr, exp_w[1]);
            end
            $display("rewind: writes at %h then %h", obs_q[0].addr, obs_q[1].addr);
        end
        m_addr = 10'h004;
    endtask

    task automatic test_reset_midburst();
        obs_q.delete(); exp_w.delete();
        IMemReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(2'd1, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'($urandom), 4'($urandom), 24'($urandom & 32'hFFF));
        end
        #2;
        RESETn = 1'b0;
        #1;
        n_checks++; if (IMemWE !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", IMemWE); end
        n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", Count); end
        n_checks++; if (IMemAddr !== 10'h000) begin n_fail++; $display("FAIL rst_addr: got %h want 000", IMemAddr); end
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        IMemReady = 1'b1;
        repeat (6) tick();
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rst_discard: got %0d writes want 0", obs_q.size()); end
        $display("reset_midburst: writes after reset=%0d", obs_q.size());
    endtask

    initial begin
        RESETn = 1'b0; ReqValid = 1'b0; Rewind = 1'b0; IMemReady = 1'b0;
        drive(2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 24'd0);
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal();
        test_random();
        test_wrap_rewind();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
